// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// The memory answers combinationally with the word at the presented byte address.
interface instruction_fetch_unit_if;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;

  modport master (output Inst_Address, input Instruction);
  modport slave  (input Inst_Address, output Instruction);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, IF/ID register, RUN/HALT control and retired-fetch counter.
// Optional feature macro FETCH_MISALIGN_CHECK_EN aligns redirect targets and flags misalignment.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [63:0] HALT_ADDR = 64'd84,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       redirect,
  input  logic [63:0]                redirect_target,
  instruction_fetch_unit_if.master   imem,
  output logic [63:0]                ifid_pc,
  output logic [31:0]                ifid_instr,
  output logic                       ifid_valid,
  output logic                       halted,
  output logic [31:0]                fetch_count,
  output logic                       misalign_err
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] count_q, count_d;
  logic [63:0] target_fix;
  logic        at_halt_addr;

  assign at_halt_addr = (state_q == ST_RUN) && (pc_q == HALT_ADDR);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic err_q, err_d;

  assign target_fix = {redirect_target[63:2], 2'b00};
  assign err_d      = err_q | (redirect & (redirect_target[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign misalign_err = err_q;
`else
  assign target_fix   = redirect_target;
  assign misalign_err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // next-state logic: redirect always returns to RUN, stall freezes
  always_comb begin
    state_d = state_q;
    if (redirect)          state_d = ST_RUN;
    else if (stall)        state_d = state_q;
    else if (at_halt_addr) state_d = ST_HALT;
  end

  // state outputs
  always_comb begin
    halted = (state_q == ST_HALT);
  end

  // datapath next values
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    if (redirect) begin
      pc_d         = target_fix;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      if ((state_q == ST_HALT) || at_halt_addr) begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem.Instruction;
        ifid_valid_d = 1'b1;
        pc_d         = pc_q + 64'd4;
        count_d      = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
    end
  end

  assign imem.Inst_Address = pc_q;
  assign ifid_pc           = ifid_pc_q;
  assign ifid_instr        = ifid_instr_q;
  assign ifid_valid        = ifid_valid_q;
  assign fetch_count       = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a spec-level model checked every cycle,
// plus literal expectations from the test plan.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [63:0] redirect_target;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid, halted, misalign_err;
  logic [31:0] fetch_count;

  instruction_fetch_unit_if imem_if();

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem(imem_if.master),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_count(fetch_count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // byte-addressed little-endian memory, 256 bytes, address wraps
  logic [7:0] mem [256];
  logic [7:0] ia0, ia1, ia2, ia3;
  assign ia0 = imem_if.Inst_Address[7:0];
  assign ia1 = ia0 + 8'd1;
  assign ia2 = ia0 + 8'd2;
  assign ia3 = ia0 + 8'd3;
  assign imem_if.Instruction = {mem[ia3], mem[ia2], mem[ia1], mem[ia0]};

  function automatic logic [31:0] rd(input logic [63:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the fetch stage
  logic        m_known = 1'b0;
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ifinstr, m_cnt;
  logic        m_valid, m_halt, m_err;

  always @(posedge clk) begin
    if (reset) begin
      m_known = 1'b1; m_pc = 64'd0; m_ifpc = 64'd0; m_ifinstr = 32'h13;
      m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'd0; m_err = 1'b0;
    end else if (m_known) begin
      if (redirect) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        m_pc  = redirect_target & ~64'd3;
        m_err = m_err || (redirect_target % 4 != 0);
`else
        m_pc  = redirect_target;
`endif
        m_ifinstr = 32'h13; m_valid = 1'b0; m_halt = 1'b0;
      end else if (!stall) begin
        if (m_halt || m_pc == 64'd84) begin
          m_ifinstr = 32'h13; m_valid = 1'b0; m_halt = 1'b1;
        end else begin
          m_ifpc = m_pc; m_ifinstr = rd(m_pc); m_valid = 1'b1;
          m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("pc",      imem_if.Inst_Address, m_pc);
      chk("ifid_pc", ifid_pc, m_ifpc);
      chk("ifid_in", {32'd0, ifid_instr}, {32'd0, m_ifinstr});
      chk("valid",   {63'd0, ifid_valid}, {63'd0, m_valid});
      chk("halted",  {63'd0, halted}, {63'd0, m_halt});
      chk("count",   {32'd0, fetch_count}, {32'd0, m_cnt});
      chk("misal",   {63'd0, misalign_err}, {63'd0, m_err});
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 64'd0;
    tick(2);
    chk("rst_instr", {32'd0, ifid_instr}, 64'h13);
    chk("rst_valid", {63'd0, ifid_valid}, 64'd0);
    chk("rst_pc",    imem_if.Inst_Address, 64'd0);
    chk("rst_cnt",   {32'd0, fetch_count}, 64'd0);
    chk("rst_halt",  {63'd0, halted}, 64'd0);

    reset = 1'b0;
    tick(3);
    chk("run3_pc",    imem_if.Inst_Address, 64'd12);
    chk("run3_ifpc",  ifid_pc, 64'd8);
    chk("run3_valid", {63'd0, ifid_valid}, 64'd1);
    chk("run3_cnt",   {32'd0, fetch_count}, 64'd3);

    tick(1);
    stall = 1'b1;
    tick(2);
    chk("stall_pc",   imem_if.Inst_Address, 64'd16);
    chk("stall_ifpc", ifid_pc, 64'd12);
    chk("stall_cnt",  {32'd0, fetch_count}, 64'd4);
    stall = 1'b0;
    tick(1);
    chk("unstall_ifpc", ifid_pc, 64'd16);

    tick(7);
    chk("at48", imem_if.Inst_Address, 64'd48);
    stall = 1'b1; redirect = 1'b1; redirect_target = 64'd76;
    tick(1);
    chk("redir_pc",    imem_if.Inst_Address, 64'd76);
    chk("redir_valid", {63'd0, ifid_valid}, 64'd0);
    stall = 1'b0; redirect = 1'b0;
    tick(1);
    chk("tgt_ifpc",  ifid_pc, 64'd76);
    chk("tgt_valid", {63'd0, ifid_valid}, 64'd1);

    tick(2);
    chk("halt_flag",  {63'd0, halted}, 64'd1);
    chk("halt_valid", {63'd0, ifid_valid}, 64'd0);
    chk("halt_pc",    imem_if.Inst_Address, 64'd84);
    tick(5);
    chk("halt_cnt",   {32'd0, fetch_count}, 64'd14);

    redirect = 1'b1; redirect_target = 64'd4;
    tick(1);
    chk("unhalt_flag", {63'd0, halted}, 64'd0);
    chk("unhalt_pc",   imem_if.Inst_Address, 64'd4);
    redirect = 1'b0;
    tick(1);
    chk("unhalt_ifpc",  ifid_pc, 64'd4);
    chk("unhalt_instr", {32'd0, ifid_instr}, 64'h342D261F);
    chk("unhalt_valid", {63'd0, ifid_valid}, 64'd1);

    redirect = 1'b1; redirect_target = 64'h4E;
    tick(1);
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_pc",  imem_if.Inst_Address, 64'h4C);
    chk("mis_err", {63'd0, misalign_err}, 64'd1);
`else
    chk("mis_pc",  imem_if.Inst_Address, 64'h4E);
    chk("mis_err", {63'd0, misalign_err}, 64'd0);
`endif
    tick(2);
    redirect = 1'b1; redirect_target = 64'd8;
    tick(1);
    redirect = 1'b0;
    chk("al_pc", imem_if.Inst_Address, 64'd8);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("sticky_err", {63'd0, misalign_err}, 64'd1);
`else
    chk("sticky_err", {63'd0, misalign_err}, 64'd0);
`endif

    tick(3);
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 64'd40;
    tick(1);
    chk("midrst_pc",    imem_if.Inst_Address, 64'd0);
    chk("midrst_valid", {63'd0, ifid_valid}, 64'd0);
    chk("midrst_cnt",   {32'd0, fetch_count}, 64'd0);
    chk("midrst_err",   {63'd0, misalign_err}, 64'd0);
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the 64-bit byte address to the memory.
- Captures the returned 32-bit little-endian instruction word into the IF/ID pipeline register.
- Handles stalls, branch redirects, a program-end halt state and a retired-fetch counter.

## Interface
Parameters:
- RESET_PC, 64'd0: PC value loaded on reset.
- HALT_ADDR, 64'd84: fetch address at which the unit stops fetching (one past last program word).
- NOP_INSTR, 32'h00000013: bubble encoding (addi x0,x0,0) placed in IF/ID when invalid.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes PC, IF/ID and state.
- redirect  in  1  taken branch/jump from a later stage.
- redirect_target  in  64  new PC when redirect=1.
- Instruction  in  32  combinational read data from instruction memory for Inst_Address.
- Inst_Address  out  64  current PC, drives instruction memory.
- ifid_pc  out  64  PC of instruction held in IF/ID.
- ifid_instr  out  32  instruction held in IF/ID.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  unit is in HALT state.
- fetch_count  out  32  number of instructions captured valid into IF/ID.
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- States: RUN, HALT. Reset state RUN.
- Inst_Address is the PC register directly; memory read is combinational, so Instruction is sampled at the same edge.
- Per-edge priority: reset > redirect > stall > halt entry > normal advance.
- reset: PC=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, state=RUN, halted=0, fetch_count=0, misalign_err=0.
- redirect (either state, stall ignored): PC=redirect_target; IF/ID loaded with NOP_INSTR, ifid_valid=0 (squashes wrong-path fetch); state=RUN.
- stall (no redirect): PC, IF/ID, state, fetch_count all hold.
- RUN, PC==HALT_ADDR, no stall/redirect: PC holds; IF/ID gets bubble (NOP_INSTR, valid 0); state=HALT.
- RUN normal: ifid_pc=PC, ifid_instr=Instruction, ifid_valid=1, PC=PC+4 (64-bit, wraps modulo 2^64), fetch_count+1.
- HALT, no redirect: PC holds; IF/ID bubble; halted=1.
- fetch_count increments exactly on edges that write ifid_valid=1; wraps 0xFFFFFFFF→0.

## Timing
- PC-to-IF/ID latency: one cycle; instruction at address A appears on ifid_instr the cycle after Inst_Address=A.
- Redirect takes effect at the edge it is sampled; the target's instruction is valid in IF/ID one edge later, so exactly one bubble per taken redirect.
- Stall asserted N cycles: outputs frozen N cycles, no bubble inserted by this unit.
- halted rises the edge after PC==HALT_ADDR is sampled in RUN; falls on the redirect edge.
- Reset mid-operation overrides stall and redirect in the same cycle.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - On redirect with redirect_target[1:0]≠0, PC loads redirect_target with bits [1:0] cleared.
  - misalign_err sets to 1 and stays set until reset.
- Undefined:
  - PC loads redirect_target unmodified.
  - misalign_err tied to 0.

## Test plan
- Reset, then 3 free-running edges with memory preloaded → Inst_Address=12, ifid_pc=8, ifid_valid=1, fetch_count=3; during reset ifid_instr=0x00000013, valid=0.
- stall=1 for 2 cycles at PC=16 → Inst_Address stays 16, IF/ID and fetch_count unchanged; release → next edge ifid_pc=16.
- redirect=1 and stall=1 together at PC=48, target=76 → next edge Inst_Address=76, ifid_valid=0; following edge ifid_pc=76, valid=1.
- Run to PC=84 → next edge halted=1, ifid_valid=0, Inst_Address=84, fetch_count frozen over 5 further cycles.
- In HALT, redirect to 4 → halted=0, Inst_Address=4; next edge ifid_pc=4, ifid_instr=mem[4..7], valid=1.
- Redirect target 0x4E:
  - With FETCH_MISALIGN_CHECK_EN → Inst_Address=0x4C, misalign_err=1, still 1 after a later aligned redirect.
  - Without → Inst_Address=0x4E, misalign_err=0.
